// File: rtl/tt_um_priority_decoder.sv
// Sequential priority decoder: rebuilds a 16-bit one-hot request mask from
// encoder result codes accepted on strobe rising edges; mask read back bytewise.
module tt_um_priority_decoder (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic        strobe, acc_mode, byte_sel, clear;
  logic        strobe_q, accept;
  logic        code_valid, code_none;
  logic [15:0] mask, onehot;
  logic        none_flag, err, ack;

  assign strobe   = uio_in[0];
  assign acc_mode = uio_in[1];
  assign byte_sel = uio_in[2];
  assign clear    = uio_in[3];

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:4]};

  assign accept     = strobe & ~strobe_q;
  assign code_valid = (ui_in[7:4] == 4'h0);
  assign code_none  = (ui_in == 8'hF0);
  assign onehot     = 16'h0001 << ui_in[3:0];

  // strobe_q resets high so a strobe held through reset release is not an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_q  <= 1'b1;
      mask      <= 16'h0000;
      none_flag <= 1'b0;
      err       <= 1'b0;
      ack       <= 1'b0;
    end else begin
      strobe_q <= strobe;
      if (clear) begin
        mask      <= 16'h0000;
        none_flag <= 1'b0;
        err       <= 1'b0;
        ack       <= 1'b0;
      end else begin
        ack <= accept;
        if (accept) begin
          if (code_valid) begin
            mask      <= acc_mode ? (mask | onehot) : onehot;
            none_flag <= 1'b0;
          end else if (code_none) begin
            if (!acc_mode) mask <= 16'h0000;
            none_flag <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end
      end
    end
  end

  assign uo_out  = byte_sel ? mask[15:8] : mask[7:0];
  assign uio_out = {ack, &mask, err, none_flag, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: doc/tt_um_priority_decoder.md
# tt_um_priority_decoder

Sequential inverse of the team's 16-bit priority encoder. It accepts 8-bit encoder result codes (index 0–15, or the all-zero marker 0xF0) on a strobe and rebuilds the 16-bit one-hot request vector in a mask register. It can either replace or accumulate (OR) the mask, and it flags malformed codes. It sits in the standard TinyTapeout user-project slot, and the mask is read back one byte at a time.

## Interface
- No parameters. Widths are fixed: 8-bit code, 16-bit mask.
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  ignored (tie-off only).
- ui_in  in  8  code: 0x00–0x0F = bit index, 0xF0 = "no bit set", anything else = invalid.
- uio_in[0]  in  1  strobe: a code is accepted on a rising edge of this input.
- uio_in[1]  in  1  acc_mode: 1 = OR decoded bit into mask, 0 = replace mask.
- uio_in[2]  in  1  byte_sel: 0 = uo_out shows mask[7:0], 1 = uo_out shows mask[15:8].
- uio_in[3]  in  1  clear: synchronous clear of mask and flags.
- uo_out  out  8  selected mask byte (combinational mux of registered mask).
- uio_out[3:0]  out  4  constant 0.
- uio_out[4]  out  1  none_flag: the last well-formed accepted code was 0xF0.
- uio_out[5]  out  1  err: sticky; an invalid code was accepted since the last clear or reset.
- uio_out[6]  out  1  full: mask == 16'hFFFF.
- uio_out[7]  out  1  ack: one-cycle pulse after each accepted strobe.
- uio_oe  out  8  constant 8'hF0.

## Operation
- Strobe edge detect:
  - A register strobe_q holds the previous uio_in[0].
  - accept = uio_in[0] & ~strobe_q.
  - strobe_q updates every cycle, including clear cycles.
- Priority per clock edge: reset > clear > accept > hold.
- Reset (rst_n=0 at edge):
  - mask=0, none_flag=0, err=0, ack=0.
  - strobe_q=1, so a strobe held high through reset release is not accepted until it goes low then high again.
- Clear (uio_in[3]=1, rst_n=1):
  - mask=0, none_flag=0, err=0, ack=0.
  - A coincident accept is dropped: no ack, and the edge is consumed.
- Accepting a code c:
  - c in 0x00–0x0F:
    - replace mode: mask = 1<<c.
    - acc mode: mask = mask | (1<<c).
    - none_flag=0.
  - c == 0xF0:
    - replace mode: mask=0.
    - acc mode: mask unchanged.
    - none_flag=1.
  - Any other c:
    - mask and none_flag unchanged; err=1.
  - ack=1 for every accepted code, valid or not.
- ack returns to 0 on the next edge unless another accept occurs. Back-to-back accepts are impossible because each needs a low cycle between them.
- Re-accumulating a bit already set leaves the mask unchanged; no error.
- full is derived from the registered mask. uo_out follows byte_sel combinationally with no added latency.
- acc_mode and byte_sel are sampled only at the accepting edge and at the output mux respectively. They have no effect otherwise.

## Timing
- A strobe rising edge present at edge N updates mask, none_flag and err at edge N. These are visible immediately after N.
- ack is high from edge N to edge N+1.
- Strobe minimum timing: high for ≥1 sampled cycle, then low for ≥1 sampled cycle, before the next accept.
- Inputs are assumed synchronous to clk. The bench drives them away from the rising edge.
- All outputs are 0 after reset. uio_oe is 8'hF0 at all times.
- Decode round trip: the encoder output of a one-hot vector with bit k set, fed in replace mode, reproduces that vector exactly.

## Test plan
- Reset with strobe held high: release rst_n with uio_in[0]=1 and code 0x05 -> no ack and mask stays 0. Then drop the strobe, raise it -> ack one cycle, mask=0x0020, uo_out=0x20 with byte_sel=0.
- Replace mode: accept 0x0F, then 0x03 -> mask=0x8000, then 0x0008. With byte_sel=1, uo_out=0x80 then 0x00.
- Accumulate: with acc_mode=1, accept 0..15 in order -> mask grows one bit at a time to 0xFFFF, full=1 only after the 16th ack. Re-accepting 0x07 leaves mask=0xFFFF.
- None marker: mask=0x0101, acc_mode=1, accept 0xF0 -> mask unchanged, none_flag=1. Then replace mode, accept 0xF0 -> mask=0, none_flag=1. Then accept 0x02 -> none_flag=0.
- Invalid code: accept 0x10, then 0xFF -> err=1 stays set, ack pulses twice, mask unchanged. Assert clear -> err=0, mask=0.
- Clear vs accept collision: strobe edge with code 0x04 in the same cycle as clear=1 -> mask=0, ack=0. Holding the strobe high afterwards gives no later accept.
